// File: rtl/debug_autobaud_mc.sv
// -----------------------------------------------------------------------------
// debug_autobaud_mc
//
// Auto-baud detector for a debug UART with several candidate RX lines.
// The block watches all candidate lines for transitions and measures the
// spacing between consecutive edges. Once MATCH_CNT consecutive pulse
// widths agree, it writes the resulting baud divisor (one-cycle wr strobe).
// It then waits for the chosen line to sit idle-high for a full counter span
// before it declares the line selected and locked.
//
// Build option:
//   AUTOBAUD_TOL_EN - when defined, pulse widths within +/-1 divisor LSB of
//                     the newest measurement count as matching; otherwise
//                     they must be exactly equal.
//
// Ports:
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   disabled  bypass measurement; the first line that toggles is selected
//   rearm     synchronous restart of detection (div and rx_sel retained)
//   rx        candidate RX lines
//   wr        one-cycle divisor write strobe
//   div       measured divisor
//   rx_sel    selected RX line, 1-based (0 = none)
//   locked    detection complete
// -----------------------------------------------------------------------------
module debug_autobaud_mc #(
   parameter  int NUM_RX    = 3,
   parameter  int CNT_W     = 14,
   parameter  int DIV_W     = 8,
   parameter  int MATCH_CNT = 3,
   localparam int SEL_W     = $clog2(NUM_RX + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              disabled,
   input  logic              rearm,
   input  logic [NUM_RX-1:0] rx,
   output logic              wr,
   output logic [DIV_W-1:0]  div,
   output logic [SEL_W-1:0]  rx_sel,
   output logic              locked
);

   typedef enum logic [1:0] {
      S_HUNT = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             state;
   state_t             state_nxt;

   logic [NUM_RX-1:0]  rx_q;
   logic [CNT_W-1:0]   cnt;
   logic [SEL_W-1:0]   cand;
   logic [DIV_W-1:0]   hist [MATCH_CNT];

   logic [NUM_RX-1:0]  rx_edge;
   logic               any_edge;
   logic               cnt_max;
   logic [SEL_W-1:0]   edge_sel;
   logic               cand_hi;
   logic               match_ok;

   logic               track;
   logic               load_cand;
   logic               shift_hist;
   logic               load_div;
   logic               set_lock;

   // Two pulse widths are considered equal if they are identical, or with the
   // tolerance build, if their signed difference is within +/-1.
   function automatic logic width_close(input logic [DIV_W-1:0] a,
                                        input logic [DIV_W-1:0] b);
`ifdef AUTOBAUD_TOL_EN
      logic signed [DIV_W:0] d;
      d = $signed({1'b0, a}) - $signed({1'b0, b});
      return (d >= -1) && (d <= 1);
`else
      return a == b;
`endif
   endfunction

   assign rx_edge  = rx ^ rx_q;
   assign any_edge = |rx_edge;
   assign cnt_max  = &cnt;

   // Lowest-index edge wins when several lines toggle in the same cycle.
   always_comb begin
      edge_sel = '0;
      for (int i = NUM_RX - 1; i >= 0; i--) begin
         if (rx_edge[i]) edge_sel = SEL_W'(i + 1);
      end
   end

   // Level of the candidate line; cand is 1-based so decode it explicitly.
   always_comb begin
      cand_hi = 1'b0;
      for (int i = 0; i < NUM_RX; i++) begin
         if (cand == SEL_W'(i + 1)) cand_hi = rx[i];
      end
   end

   // A zero-width history entry means "nothing measured" and never matches.
   always_comb begin
      match_ok = (hist[0] != '0);
      for (int i = 1; i < MATCH_CNT; i++) begin
         if (!width_close(hist[i], hist[0])) match_ok = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_HUNT;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (rearm) begin
         state_nxt = S_HUNT;
      end else begin
         case (state)
            S_HUNT: begin
               if (disabled) begin
                  if (any_edge) state_nxt = S_WAIT;
               end else if (!any_edge && match_ok) begin
                  state_nxt = S_WAIT;
               end
            end
            S_WAIT: begin
               if ((cnt_max && cand_hi) || disabled) state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_DONE;
            default: state_nxt = S_HUNT;
         endcase
      end
   end

   always_comb begin
      track      = (state != S_DONE);
      load_cand  = !rearm && (state == S_HUNT) && any_edge;
      // Saturated counts mean the line was idle, not a bit period.
      shift_hist = !rearm && (state == S_HUNT) && any_edge && !cnt_max;
      load_div   = !rearm && (state == S_HUNT) && !disabled && !any_edge && match_ok;
      set_lock   = !rearm && (state == S_WAIT) && ((cnt_max && cand_hi) || disabled);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_q   <= '0;
         cnt    <= '0;
         cand   <= '0;
         wr     <= 1'b0;
         div    <= '0;
         rx_sel <= '0;
         locked <= 1'b0;
         for (int i = 0; i < MATCH_CNT; i++) hist[i] <= '0;
      end else begin
         wr <= load_div;
         if (rearm) begin
            // Resample the lines so a level change while frozen in DONE is
            // not mistaken for a fresh edge.
            rx_q   <= rx;
            cnt    <= '0;
            cand   <= '0;
            locked <= 1'b0;
            for (int i = 0; i < MATCH_CNT; i++) hist[i] <= '0;
         end else begin
            if (track) begin
               rx_q <= rx;
               if (any_edge)     cnt <= '0;
               else if (!cnt_max) cnt <= cnt + 1'b1;
            end
            if (load_cand) cand <= edge_sel;
            if (shift_hist) begin
               for (int i = MATCH_CNT - 1; i > 0; i--) hist[i] <= hist[i-1];
               hist[0] <= cnt[CNT_W-2 -: DIV_W];
            end
            if (load_div) div <= hist[0];
            if (set_lock) begin
               rx_sel <= cand;
               locked <= 1'b1;
            end
         end
      end
   end

endmodule

// File: doc/debug_autobaud_mc.md
DEBUG_AUTOBAUD_MC -- requirements
Module: debug_autobaud_mc

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- NUM_RX, 3, candidate RX inputs (1..8)
- CNT_W, 14, pulse-counter width (>= DIV_W+2)
- DIV_W, 8, divisor width
- MATCH_CNT, 3, consecutive matching pulses needed to lock (2..4)
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, system clock
- rst_n, in, 1, asynchronous active-low reset
- disabled, in, 1, bypass measurement; select first active RX only
- rearm, in, 1, synchronous restart of detection
- rx, in, NUM_RX, candidate RX lines
- wr, out, 1, one-cycle divisor write strobe
- div, out, DIV_W, measured divisor
- rx_sel, out, SEL_W = clog2(NUM_RX+1), selected RX (1-based; 0 = none)
- locked, out, 1, detection complete
REQ-003 The block SHALL use one clock, clk; reset SHALL be asynchronous and active-low on rst_n.

Function
REQ-004 State machine SHALL be HUNT -> WAIT -> DONE; reset enters HUNT.
REQ-005 rx_q SHALL register rx every cycle in HUNT and WAIT; edge = rx XOR rx_q; any_edge = OR of edge bits.
REQ-006 Pulse counter cnt (CNT_W bits) SHALL clear on any_edge, else increment, saturating at MAX = all ones.
REQ-007 In HUNT on any_edge, cand SHALL load (lowest index with an edge)+1; simultaneous edges SHALL resolve to the lowest index.
REQ-008 In HUNT on any_edge with cnt != MAX, history SHALL shift in cnt[CNT_W-2 -: DIV_W]; saturated pulses SHALL NOT be recorded.
REQ-009 In HUNT, on a cycle without any_edge where all MATCH_CNT history entries match h[0] and h[0] != 0: div <= h[0], wr = 1 for exactly one cycle (the next), go to WAIT.
REQ-010 In HUNT with disabled = 1, the first any_edge SHALL load cand and go to WAIT without wr; div SHALL be unchanged.
REQ-011 In WAIT, edges SHALL clear cnt; when cnt == MAX and rx[cand-1] == 1, or disabled = 1, the block SHALL set rx_sel <= cand and locked <= 1, and go to DONE.
REQ-012 In DONE, rx_q SHALL freeze, edges SHALL be ignored, and all outputs SHALL hold.
REQ-013 rearm SHALL override all other conditions in any state:
- go to HUNT
- clear history, cnt, cand, wr and locked
- retain div and rx_sel
REQ-014 Outputs SHALL be registered; wr SHALL never assert outside the cycle after the REQ-009 match.

Reset
REQ-015 Reset SHALL force state = HUNT, wr = 0, div = 0, rx_sel = 0, locked = 0, cand = 0, cnt = 0, rx_q = 0, and every history entry = 0.
REQ-016 Reset asserted mid-pulse or mid-WAIT SHALL abort immediately; no wr SHALL follow deassertion until a new match occurs.

Configuration
REQ-017 With macro AUTOBAUD_TOL_EN defined, "match" SHALL mean |h[i] - h[0]| <= 1 for every entry, and div SHALL load h[0].
REQ-018 Without AUTOBAUD_TOL_EN, "match" SHALL mean exact equality of all entries.

Verification (NUM_RX=3, CNT_W=14, DIV_W=8, MATCH_CNT=3)
REQ-019 Three pulses of 1025 clks each on rx[1] -> one wr pulse with div = 0x20, state WAIT, cand = 2.
REQ-020 After REQ-019, hold rx[1] = 1 for 16384 clks -> rx_sel = 2, locked = 1; later rx toggles cause no change.
REQ-021 Simultaneous edges on rx[0] and rx[2] -> cand = 1.
REQ-022 Pulses measuring 0x20, 0x21, 0x20 -> wr with div = 0x20 only if AUTOBAUD_TOL_EN is defined; otherwise no wr.
REQ-023 disabled = 1 with the first edge on rx[2] -> rx_sel = 3, locked = 1 within 2 clks, no wr, div = 0.
REQ-024 Pulse rearm while in DONE -> locked = 0, div and rx_sel retained; a new 3-pulse train of 2049 clks -> div = 0x40.
